// File: rtl/fm_pingpong_buffer_pkg.sv
// fm_pingpong_buffer_pkg: shared sizing defaults and external-memory offsets for the ping-pong buffer
package fm_pingpong_buffer_pkg;
    localparam int DEPTH_DEF = 1024;
    localparam int AW_DEF = 10;
    localparam int DW_DEF = 16;
    localparam logic [15:0] EXT_BANK0_OFFSET = 16'h0000;
    localparam logic [15:0] EXT_BANK1_OFFSET = 16'h0400;
endpackage

// File: rtl/fm_pingpong_buffer_bank.sv
// fm_bank: DEPTH x DW RAM with one write port and one registered read port
// ports: clk; we/waddr/wdata write port; re/raddr read request; rdata valid the cycle after re
module fm_bank #(
    parameter int DEPTH = 1024,
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fm_pingpong_buffer.sv
// fm_pingpong_buffer: two-bank DMA fill / consumer drain ping-pong buffer
// ports: clk, rst (sync, active-high); DMA side write/ram_addr/ram_data/fill_done;
// consumer side rd_en/rd_addr/drain_done -> rd_data/rd_valid; status fill_ready,
// drain_ready, fill_count and sticky err
import fm_pingpong_buffer_pkg::*;
module fm_pingpong_buffer #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic [15:0]   ram_addr,
    input  logic [31:0]   ram_data,
    input  logic          fill_done,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          drain_done,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          fill_ready,
    output logic          drain_ready,
    output logic [AW:0]   fill_count,
    output logic          err
);
    logic [1:0] full, full_nxt;
    logic fill_sel, drain_sel, rd_sel;
    logic wr_ok, rd_ok, fill_ok, drain_ok, bad;
    logic [DW-1:0] bank_rdata [2];
    logic unused_bits;
    assign unused_bits = ^ram_data;
    assign fill_ready = !full[fill_sel];
    assign drain_ready = full[drain_sel];
    assign wr_ok = write && fill_ready && (int'(ram_addr) < DEPTH);
    assign rd_ok = rd_en && drain_ready;
    assign fill_ok = fill_done && fill_ready;
    assign drain_ok = drain_done && drain_ready;
    assign bad = (write && !wr_ok) || (fill_done && !fill_ready) ||
                 (drain_done && !drain_ready) || (rd_en && !drain_ready);
    // fill and drain always point at different banks when both are accepted,
    // so setting one flag and clearing the other never collide
    always_comb begin
        full_nxt = full;
        if (fill_ok) full_nxt[fill_sel] = 1'b1;
        if (drain_ok) full_nxt[drain_sel] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            fill_sel <= 1'b0;
            drain_sel <= 1'b0;
            fill_count <= '0;
            err <= 1'b0;
            rd_valid <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full <= full_nxt;
            fill_sel <= fill_sel ^ fill_ok;
            drain_sel <= drain_sel ^ drain_ok;
            fill_count <= fill_ok ? '0 :
                          (wr_ok && fill_count < (AW+1)'(DEPTH)) ? fill_count + 1'b1 : fill_count;
            err <= err | bad;
            rd_valid <= rd_ok;
            rd_sel <= drain_sel;
        end
    end
    for (genvar b = 0; b < 2; b++) begin : g_bank
        fm_bank #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_bank (
            .clk   (clk),
            .we    (wr_ok && fill_sel == 1'(b)),
            .waddr (ram_addr[AW-1:0]),
            .wdata (ram_data[DW-1:0]),
            .re    (rd_ok && drain_sel == 1'(b)),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end
    // bank outputs hold stale data between reads; mask them unless a read completed
    assign rd_data = rd_valid ? bank_rdata[rd_sel] : '0;
endmodule

// File: tb/tb_fm_pingpong_buffer.sv
// tb_fm_pingpong_buffer: vector table, corner sequences and random traffic against an occupancy-based model
module tb_fm_pingpong_buffer;
    import fm_pingpong_buffer_pkg::*;
    localparam int DEPTH = DEPTH_DEF;
    localparam int AW = AW_DEF;
    localparam int DW = DW_DEF;

    logic clk = 1'b0, rst = 1'b1;
    logic write = 1'b0, fill_done = 1'b0, drain_done = 1'b0, rd_en = 1'b0;
    logic [15:0] ram_addr = '0;
    logic [31:0] ram_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic rd_valid, fill_ready, drain_ready, err;
    logic [AW:0] fill_count;

    always #5 clk = ~clk;

    fm_pingpong_buffer dut (
        .clk(clk), .rst(rst), .write(write), .ram_addr(ram_addr), .ram_data(ram_data),
        .fill_done(fill_done), .rd_en(rd_en), .rd_addr(rd_addr), .drain_done(drain_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .fill_ready(fill_ready),
        .drain_ready(drain_ready), .fill_count(fill_count), .err(err)
    );

    // model: banks are consumed in ping-pong order, so the number of completed fills
    // and drains fully determines which bank is filled/drained and the readiness flags
    int fills, drains, cnt;
    bit m_err, m_v, m_known;
    logic [DW-1:0] m_d;
    logic [DW-1:0] mem [2][DEPTH];
    bit written [2][DEPTH];
    int n_cmp = 0, n_fail = 0;

    typedef struct {
        bit w; int a; int d; bit fd; bit dd; bit re; int ra;
        bit efr; bit edr; int ecnt; bit eerr; bit ev; int ed;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("fill_ready", 32'(fill_ready), 32'((fills - drains) < 2));
        check("drain_ready", 32'(drain_ready), 32'((fills - drains) > 0));
        check("fill_count", 32'(fill_count), 32'(cnt));
        check("err", 32'(err), 32'(m_err));
        check("rd_valid", 32'(rd_valid), 32'(m_v));
        if (m_known) check("rd_data", 32'(rd_data), 32'(m_d));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write = 0; fill_done = 0; drain_done = 0; rd_en = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        fills = 0; drains = 0; cnt = 0; m_err = 0; m_v = 0; m_known = 1; m_d = '0;
        check_model();
    endtask

    task automatic step(input bit w, input int a, input int d, input bit fd, input bit dd,
                        input bit re, input int ra);
        int occ;
        bit fr, dr, wok;
        write = w; ram_addr = 16'(a); ram_data = 32'(d);
        fill_done = fd; drain_done = dd; rd_en = re; rd_addr = AW'(ra);
        occ = fills - drains;
        fr = occ < 2;
        dr = occ > 0;
        wok = w && fr && a < DEPTH;
        if (wok) begin
            mem[fills % 2][a] = DW'(d);
            written[fills % 2][a] = 1'b1;
            if (cnt < DEPTH) cnt++;
        end else if (w) m_err = 1;
        m_v = re && dr;
        m_known = 1;
        m_d = '0;
        if (m_v) begin
            m_d = mem[drains % 2][ra];
            m_known = written[drains % 2][ra];
        end else if (re) m_err = 1;
        if (fd) begin
            if (fr) begin fills++; cnt = 0; end
            else m_err = 1;
        end
        if (dd) begin
            if (dr) drains++;
            else m_err = 1;
        end
        @(posedge clk); #1;
        write = 0; fill_done = 0; drain_done = 0; rd_en = 0;
        check_model();
    endtask

    task automatic wr(input int a, input int d); step(1, a, d, 0, 0, 0, 0); endtask
    task automatic rd(input int a); step(0, 0, 0, 0, 0, 1, a); endtask
    task automatic idle(input bit fd, input bit dd); step(0, 0, 0, fd, dd, 0, 0); endtask

    initial begin
        for (int i = 0; i < 5; i++)
            vecs[i] = '{1'b1, i, 10 + i, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, i + 1, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0};
        for (int i = 0; i < 5; i++)
            vecs[6 + i] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, i, 1'b1, 1'b1, 0, 1'b0, 1'b1, 10 + i};
        vecs[11] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].fd, vecs[i].dd, vecs[i].re, vecs[i].ra);
            check($sformatf("vec%0d_fill_ready", i), 32'(fill_ready), 32'(vecs[i].efr));
            check($sformatf("vec%0d_drain_ready", i), 32'(drain_ready), 32'(vecs[i].edr));
            check($sformatf("vec%0d_fill_count", i), 32'(fill_count), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].eerr));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].ed));
        end

        // both banks full: further write dropped, contents intact
        do_reset();
        for (int i = 0; i < 5; i++) wr(i, 100 + i);
        idle(1, 0);
        for (int i = 0; i < 5; i++) wr(i, 200 + i);
        idle(1, 0);
        check("full_fill_ready", 32'(fill_ready), 32'(0));
        wr(3, 999);
        check("full_drop_err", 32'(err), 32'(1));
        for (int i = 0; i < 5; i++) begin
            rd(i);
            check("full_bank0_data", 32'(rd_data), 32'(100 + i));
        end
        idle(0, 1);
        for (int i = 0; i < 5; i++) begin
            rd(i);
            check("full_bank1_data", 32'(rd_data), 32'(200 + i));
        end

        // simultaneous fill_done and drain_done
        do_reset();
        wr(0, 7);
        idle(1, 0);
        wr(0, 8);
        idle(1, 1);
        check("simul_fill_ready", 32'(fill_ready), 32'(1));
        check("simul_drain_ready", 32'(drain_ready), 32'(1));
        check("simul_err", 32'(err), 32'(0));
        rd(0);
        check("simul_drain_bank1", 32'(rd_data), 32'(8));
        wr(0, 9);
        check("simul_fill_bank0_count", 32'(fill_count), 32'(1));

        // out-of-range write and read with nothing to drain
        do_reset();
        wr(1, 55);
        wr(1024, 66);
        check("oor_err", 32'(err), 32'(1));
        check("oor_count", 32'(fill_count), 32'(1));
        rd(1);
        check("empty_rd_valid", 32'(rd_valid), 32'(0));
        check("empty_rd_data", 32'(rd_data), 32'(0));

        // reset with one bank full and err set
        do_reset();
        wr(0, 1);
        idle(1, 0);
        wr(2000, 0);
        wr(0, 2);
        do_reset();
        check("rst_drain_ready", 32'(drain_ready), 32'(0));
        check("rst_fill_ready", 32'(fill_ready), 32'(1));
        check("rst_err", 32'(err), 32'(0));
        check("rst_count", 32'(fill_count), 32'(0));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? 1024 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                      int'($urandom),
                      $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                      $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
